burst_lane_ram_fifo: RTL and testbench

//  Multi-lane burst-write RAM buffer for the collision pipeline. It accepts up to LANES

---
 rtl/burst_lane_ram_fifo.sv | 149 ++++++++++++++
 tb/tb_burst_lane_ram_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_lane_ram_fifo.sv
// burst_lane_ram_fifo
// Multi-lane burst-write circular RAM buffer. A parallel producer writes up to
// LANES words per beat; a serial consumer drains one word per cycle through a
// registered output stage. Provides occupancy, full/empty flags, a synchronous
// flush and sticky error flags for overrun and illegal lane counts.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge where valid && ready are both high.
//   wr_ready is derived from level only and never looks at wr_valid.
//   rd_valid is a register and never looks at rd_ready; once high it stays high
//   with stable rd_data until the consumer takes the word.
//   A write beat offered while wr_ready is low is dropped and flagged (err_ovf).
module burst_lane_ram_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 7,
  parameter int DEPTH      = 96,
  parameter int CNT_W      = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [CNT_W-1:0]            wr_count,
  input  logic [LANES*DATA_WIDTH-1:0] wr_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic [CNT_W-1:0]            level,
  output logic                        full,
  output logic                        empty,
  output logic                        err_ovf,
  output logic                        err_cnt
);

  // Constants sized to the pointer/level width so all compares are width-clean.
  localparam logic [CNT_W:0]   DEPTH_X  = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] LANES_C  = CNT_W'(LANES);
  localparam logic [CNT_W-1:0] FULL_TH  = CNT_W'(DEPTH - LANES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  // Storage; contents are not reset, only pointers and level are.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic [CNT_W-1:0] wr_ptr_next;
  logic [CNT_W-1:0] rd_ptr_inc;
  logic [CNT_W-1:0] level_next;
  logic [CNT_W:0]   wr_sum;

  logic             count_ok;
  logic             accept;
  logic             load;
  logic             rd_take;

  logic [CNT_W-1:0] lane_addr [LANES];
  logic             lane_en   [LANES];

  // Status flags: full means a maximum-size beat might not fit.
  assign full     = level > FULL_TH;
  assign wr_ready = !full;
  assign empty    = (level == '0) && !rd_valid;

  // Write acceptance: legal lane count and room for a full beat.
  assign count_ok = (wr_count != '0) && (wr_count <= LANES_C);
  assign accept   = wr_valid && wr_ready && count_ok;

  // Output stage refills whenever it is empty or its word is being taken.
  assign rd_take  = rd_valid && rd_ready;
  assign load     = (level != '0) && (!rd_valid || rd_ready);

  // Per-lane RAM address with explicit wrap: DEPTH need not be a power of two.
  // wr_ptr < DEPTH and lane index < LANES <= DEPTH, so one subtraction suffices.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [CNT_W:0] lane_sum;
    assign lane_sum     = {1'b0, wr_ptr} + (CNT_W+1)'(g);
    assign lane_addr[g] = (lane_sum >= DEPTH_X) ? CNT_W'(lane_sum - DEPTH_X)
                                                : CNT_W'(lane_sum);
    assign lane_en[g]   = CNT_W'(g) < wr_count;
  end

  // Pointer advance, used only for accepted beats (wr_count <= LANES).
  assign wr_sum      = {1'b0, wr_ptr} + {1'b0, wr_count};
  assign wr_ptr_next = (wr_sum >= DEPTH_X) ? CNT_W'(wr_sum - DEPTH_X)
                                           : CNT_W'(wr_sum);
  assign rd_ptr_inc  = (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;

  // Occupancy after this edge: words written minus the word moved to rd_data.
  always_comb begin
    level_next = level;
    if (accept) begin
      level_next = level_next + wr_count;
    end
    if (load) begin
      level_next = level_next - 1'b1;
    end
  end

  // RAM write port: every enabled lane of an accepted beat lands in one edge.
  always_ff @(posedge clk) begin
    if (accept && !flush) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_en[i]) begin
          mem[lane_addr[i]] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Pointers, level, output register and sticky errors; flush overrides all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      err_ovf  <= 1'b0;
      err_cnt  <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      err_ovf  <= 1'b0;
      err_cnt  <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr_next;
      end
      if (load) begin
        rd_data  <= mem[rd_ptr];
        rd_valid <= 1'b1;
        rd_ptr   <= rd_ptr_inc;
      end else if (rd_take) begin
        rd_valid <= 1'b0;
      end
      level <= level_next;
      if (wr_valid && !wr_ready) begin
        err_ovf <= 1'b1;
      end
      if (wr_valid && wr_ready && !count_ok) begin
        err_cnt <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_burst_lane_ram_fifo.sv
// tb_burst_lane_ram_fifo
// Directed bench for burst_lane_ram_fifo with default parameters
// (32-bit words, 7 lanes, 96 entries). Expected read data comes from a queue
// filled when the bench writes a beat it knows will be accepted; a monitor
// pops it whenever a word is taken.
module tb_burst_lane_ram_fifo;

  localparam int DW    = 32;
  localparam int LANES = 7;
  localparam int DEPTH = 96;
  localparam int CW    = 7;

  // ---------------- clock / reset / DUT ----------------
  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  flush;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [CW-1:0]         wr_count;
  logic [LANES*DW-1:0]   wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DW-1:0]         rd_data;
  logic [CW-1:0]         level;
  logic                  full;
  logic                  empty;
  logic                  err_ovf;
  logic                  err_cnt;

  always #5 clk = ~clk;

  burst_lane_ram_fifo #(
    .DATA_WIDTH(DW), .LANES(LANES), .DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_count(wr_count), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .level(level), .full(full), .empty(empty),
    .err_ovf(err_ovf), .err_cnt(err_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            n_chk = 0;
  int            n_err = 0;
  int            rd_words = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // A word is taken at the next rising edge when rd_valid && rd_ready hold at
  // the falling edge (inputs only change just after rising edges).
  always @(negedge clk) begin
    if (rst_n && !flush && rd_valid && rd_ready) begin
      check_val("sb_has_word", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check_val("rd_data", rd_data, exp_q.pop_front());
      end
      rd_words++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int cnt, input logic [31:0] base, input bit will_accept);
    wr_valid = 1'b1;
    wr_count = CW'(cnt);
    for (int i = 0; i < LANES; i++) begin
      wr_data[i*DW +: DW] = base + 32'(i);
    end
    if (will_accept) begin
      for (int i = 0; i < cnt; i++) begin
        exp_q.push_back(base + 32'(i));
      end
    end
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b1;
    flush    = 1'b0;
    wr_valid = 1'b0;
    wr_count = '0;
    wr_data  = '0;
    rd_ready = 1'b0;
    exp_q.delete();
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_level", 32'(level), 32'd0);
    check_val("rst_empty", 32'(empty), 32'd1);
    check_val("rst_wr_ready", 32'(wr_ready), 32'd1);
    check_val("rst_full", 32'(full), 32'd0);
    check_val("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_val("rst_rd_data", rd_data, 32'd0);
    check_val("rst_errs", 32'({err_ovf, err_cnt}), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && !empty; i++) begin
      tick();
    end
    check_val("drain_empty", 32'(empty), 32'd1);
    check_val("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    // 1: single beat of 7, latency and back-to-back readout
    do_reset();
    rd_ready = 1'b1;
    rd_words = 0;
    send(7, 32'h10, 1'b1);                  // accepted at edge N
    check_val("t1_level_after_write", 32'(level), 32'd7);
    check_val("t1_rd_valid_N", 32'(rd_valid), 32'd0);
    for (int k = 1; k <= 7; k++) begin      // edges N+1 .. N+7 each present a word
      tick();
      check_val("t1_rd_valid_stream", 32'(rd_valid), 32'd1);
    end
    tick();                                  // edge N+8: last word gone
    check_val("t1_empty", 32'(empty), 32'd1);
    check_val("t1_words", 32'(rd_words), 32'd7);

    // 2: fill with rd_ready low; one word moves to the output register, so
    // 91 words held = 90 in RAM + 1 in rd_data
    do_reset();
    for (int b = 0; b < 13; b++) begin
      send(7, 32'h1000 + 32'(b*16), 1'b1);
      if (b == 11) begin
        check_val("t2_level_b12", 32'(level), 32'd83);
        check_val("t2_full_b12", 32'(full), 32'd0);
      end
    end
    check_val("t2_level_b13", 32'(level), 32'd90);
    check_val("t2_full", 32'(full), 32'd1);
    check_val("t2_wr_ready", 32'(wr_ready), 32'd0);
    check_val("t2_rd_valid", 32'(rd_valid), 32'd1);
    send(7, 32'h2000, 1'b0);                 // refused beat
    check_val("t2_err_ovf", 32'(err_ovf), 32'd1);
    check_val("t2_level_after_ovf", 32'(level), 32'd90);
    check_val("t2_err_cnt", 32'(err_cnt), 32'd0);
    rd_ready = 1'b1;
    wait_empty(200);

    // 3: advance pointers to 93, then a beat that wraps 93,94,95,0,1,2,3
    do_reset();
    rd_ready = 1'b1;
    for (int b = 0; b < 13; b++) begin
      send(7, 32'h100 + 32'(b*16), 1'b1);
      wait_empty(20);
    end
    send(2, 32'h900, 1'b1);
    wait_empty(20);
    send(7, 32'hA00, 1'b1);
    check_val("t3_level_wrap", 32'(level), 32'd7);
    wait_empty(20);

    // 4: partial beats and illegal lane counts
    do_reset();
    send(3, 32'h300, 1'b1);
    send(1, 32'h310, 1'b1);
    // 4 words held = 3 in RAM + 1 in rd_data
    check_val("t4_level", 32'(level), 32'd3);
    check_val("t4_rd_valid", 32'(rd_valid), 32'd1);
    send(0, 32'h320, 1'b0);
    check_val("t4_err_cnt_zero", 32'(err_cnt), 32'd1);
    check_val("t4_level_zero", 32'(level), 32'd3);
    send(8, 32'h330, 1'b0);
    check_val("t4_level_eight", 32'(level), 32'd3);
    check_val("t4_err_ovf", 32'(err_ovf), 32'd0);
    rd_ready = 1'b1;
    wait_empty(20);
    check_val("t4_err_cnt_sticky", 32'(err_cnt), 32'd1);

    // 5: steady state, beat of 2 every cycle while draining 1/cycle
    do_reset();
    rd_ready = 1'b1;
    for (int b = 1; b <= 10; b++) begin
      send(2, 32'h500 + 32'(b*2), 1'b1);
      if (b == 5)  check_val("t5_level_b5", 32'(level), 32'd6);
      if (b == 10) check_val("t5_level_b10", 32'(level), 32'd11);
    end
    wait_empty(40);

    // 6: flush at level 20 with a write offered, then async reset mid-beat
    do_reset();
    for (int b = 0; b < 3; b++) begin
      send(7, 32'h600 + 32'(b*16), 1'b1);
    end
    check_val("t6_level_20", 32'(level), 32'd20);
    send(0, 32'h6F0, 1'b0);
    check_val("t6_err_cnt_set", 32'(err_cnt), 32'd1);
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_count = CW'(7);
    rd_ready = 1'b1;
    tick();
    flush    = 1'b0;
    wr_valid = 1'b0;
    exp_q.delete();
    check_val("t6_flush_level", 32'(level), 32'd0);
    check_val("t6_flush_empty", 32'(empty), 32'd1);
    check_val("t6_flush_rd_valid", 32'(rd_valid), 32'd0);
    check_val("t6_flush_errs", 32'({err_ovf, err_cnt}), 32'd0);
    send(4, 32'hC00, 1'b1);
    wait_empty(20);

    rd_ready = 1'b0;
    send(5, 32'hD00, 1'b1);
    tick();
    check_val("t6_pre_rst_level", 32'(level), 32'd4);
    wr_valid = 1'b1;
    wr_count = CW'(7);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_val("t6_rst_level", 32'(level), 32'd0);
    check_val("t6_rst_rd_valid", 32'(rd_valid), 32'd0);
    check_val("t6_rst_rd_data", rd_data, 32'd0);
    check_val("t6_rst_empty", 32'(empty), 32'd1);
    check_val("t6_rst_wr_ready", 32'(wr_ready), 32'd1);
    wr_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    rd_ready = 1'b1;
    send(2, 32'hE00, 1'b1);
    wait_empty(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
